// File: rtl/weight_bank_pkg.sv
// rtl/weight_bank_pkg.sv - shared types, defaults and index helper for the ping/pong weight bank
package weight_bank_pkg;

    localparam int DEF_NUM_BANKS = 8;
    localparam int DEF_KPOS      = 9;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_DEPTH     = 512;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } load_state_e;

    // Lowest bit of weight (bank, pos) inside the position-major read word.
    function automatic int pm_bit(input int bank, input int pos,
                                  input int num_banks, input int data_w);
        return (pos * num_banks + bank) * data_w;
    endfunction

endpackage

// File: rtl/weight_bank_pp_if.sv
// rtl/weight_bank_pp_if.sv - loader, swap and read signals of the ping/pong weight bank
interface weight_bank_pp_if #(
    parameter int NUM_BANKS = 8,
    parameter int KPOS      = 9,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 512,
    parameter int AW        = $clog2(DEPTH)
);
    logic                            load_start;
    logic [AW:0]                     load_len;
    logic                            wr_valid;
    logic                            wr_ready;
    logic [KPOS*DATA_W-1:0]          wr_data;
    logic                            swap_req;
    logic                            rd_en;
    logic [AW-1:0]                   rd_addr;
    logic [NUM_BANKS-1:0]            rd_mask;
    logic [NUM_BANKS*KPOS*DATA_W-1:0] rd_data;
    logic                            rd_valid;
    logic                            active_buf;
    logic                            shadow_full;
    logic                            load_busy;

    modport master (
        output load_start, load_len, wr_valid, wr_data, swap_req,
               rd_en, rd_addr, rd_mask,
        input  wr_ready, rd_data, rd_valid, active_buf, shadow_full, load_busy
    );

    modport slave (
        input  load_start, load_len, wr_valid, wr_data, swap_req,
               rd_en, rd_addr, rd_mask,
        output wr_ready, rd_data, rd_valid, active_buf, shadow_full, load_busy
    );
endinterface

// File: rtl/weight_bank_ram.sv
// rtl/weight_bank_ram.sv - simple dual-port RAM with registered read, one bank of one buffer
module weight_bank_ram #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 72,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/weight_bank_pp.sv
// rtl/weight_bank_pp.sv - double-buffered NUM_BANKS x DEPTH weight store
// Stream loader fills the shadow copy while the conv array reads the active copy.
module weight_bank_pp
    import weight_bank_pkg::*;
#(
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    parameter int KPOS      = DEF_KPOS,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    weight_bank_pp_if.slave bus
);
    localparam int WW = KPOS * DATA_W;
    localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int RW = NUM_BANKS * WW;

    load_state_e          state_q, state_d;
    logic [AW:0]          len_q, len_d;
    logic [BW-1:0]        bank_cnt_q, bank_cnt_d;
    logic [AW-1:0]        addr_cnt_q, addr_cnt_d;
    logic                 shadow_full_q, shadow_full_d;
    logic                 active_buf_q, active_buf_d;
    logic                 wr_ready_q, wr_ready_d;
    logic                 load_busy_q, load_busy_d;

    logic                 s1_valid_q, s1_valid_d;
    logic [AW-1:0]        s1_addr_q, s1_addr_d;
    logic [NUM_BANKS-1:0] s1_mask_q, s1_mask_d;
    logic                 s1_sel_q, s1_sel_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [NUM_BANKS-1:0] s2_mask_q, s2_mask_d;
    logic                 s2_sel_q, s2_sel_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [RW-1:0]        rd_data_q, rd_data_d;

    logic                 beat;
    logic [WW-1:0]        ram_rdata [2][NUM_BANKS];

    assign beat = bus.wr_valid && wr_ready_q;

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        bank_cnt_d    = bank_cnt_q;
        addr_cnt_d    = addr_cnt_q;
        shadow_full_d = shadow_full_q;
        active_buf_d  = active_buf_q;

        // Swap only once the shadow copy is complete; a partially loaded copy never goes live.
        if (bus.swap_req && shadow_full_q) begin
            active_buf_d  = ~active_buf_q;
            shadow_full_d = 1'b0;
            state_d       = ST_IDLE;
        end

        unique case (state_q)
            ST_IDLE, ST_FULL: begin
                if (bus.load_start && (bus.load_len != '0)) begin
                    state_d       = ST_LOAD;
                    len_d         = bus.load_len;
                    bank_cnt_d    = '0;
                    addr_cnt_d    = '0;
                    shadow_full_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (beat) begin
                    if (bank_cnt_q == BW'(NUM_BANKS - 1)) begin
                        bank_cnt_d = '0;
                        if ({1'b0, addr_cnt_q} == len_q - (AW+1)'(1)) begin
                            state_d       = ST_FULL;
                            shadow_full_d = 1'b1;
                        end else begin
                            addr_cnt_d = addr_cnt_q + AW'(1);
                        end
                    end else begin
                        bank_cnt_d = bank_cnt_q + BW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        wr_ready_d  = (state_d == ST_LOAD);
        load_busy_d = (state_d == ST_LOAD);
    end

    always_comb begin
        s1_valid_d = bus.rd_en;
        s1_addr_d  = bus.rd_en ? bus.rd_addr : s1_addr_q;
        s1_mask_d  = bus.rd_en ? bus.rd_mask : s1_mask_q;
        s1_sel_d   = bus.rd_en ? active_buf_q : s1_sel_q;
        s2_valid_d = s1_valid_q;
        s2_mask_d  = s1_valid_q ? s1_mask_q : s2_mask_q;
        s2_sel_d   = s1_valid_q ? s1_sel_q : s2_sel_q;
        rd_valid_d = s2_valid_q;
        rd_data_d  = rd_data_q;
        if (s2_valid_q) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int p = 0; p < KPOS; p++) begin
                    rd_data_d[pm_bit(b, p, NUM_BANKS, DATA_W) +: DATA_W] =
                        s2_mask_q[b] ? ram_rdata[s2_sel_q][b][p*DATA_W +: DATA_W] : '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            len_q         <= '0;
            bank_cnt_q    <= '0;
            addr_cnt_q    <= '0;
            shadow_full_q <= 1'b0;
            active_buf_q  <= 1'b0;
            wr_ready_q    <= 1'b0;
            load_busy_q   <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_addr_q     <= '0;
            s1_mask_q     <= '0;
            s1_sel_q      <= 1'b0;
            s2_valid_q    <= 1'b0;
            s2_mask_q     <= '0;
            s2_sel_q      <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            bank_cnt_q    <= bank_cnt_d;
            addr_cnt_q    <= addr_cnt_d;
            shadow_full_q <= shadow_full_d;
            active_buf_q  <= active_buf_d;
            wr_ready_q    <= wr_ready_d;
            load_busy_q   <= load_busy_d;
            s1_valid_q    <= s1_valid_d;
            s1_addr_q     <= s1_addr_d;
            s1_mask_q     <= s1_mask_d;
            s1_sel_q      <= s1_sel_d;
            s2_valid_q    <= s2_valid_d;
            s2_mask_q     <= s2_mask_d;
            s2_sel_q      <= s2_sel_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
        end
    end

    // Writes target only the shadow copy, so the active copy is stable for the conv array.
    for (genvar gb = 0; gb < 2; gb++) begin : g_buf
        for (genvar gk = 0; gk < NUM_BANKS; gk++) begin : g_bank
            logic we;
            logic re;
            assign we = beat && (bank_cnt_q == BW'(gk)) && (active_buf_q != gb[0]);
            assign re = s1_valid_q && (s1_sel_q == gb[0]);
            weight_bank_ram #(
                .DEPTH (DEPTH),
                .WIDTH (WW),
                .AW    (AW)
            ) u_ram (
                .clk   (clk),
                .we    (we),
                .waddr (addr_cnt_q),
                .wdata (bus.wr_data),
                .re    (re),
                .raddr (s1_addr_q),
                .rdata (ram_rdata[gb][gk])
            );
        end
    end

    assign bus.wr_ready    = wr_ready_q;
    assign bus.load_busy   = load_busy_q;
    assign bus.shadow_full = shadow_full_q;
    assign bus.active_buf  = active_buf_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_data     = rd_data_q;
endmodule

// File: tb/tb_weight_bank_pp.sv
// tb/tb_weight_bank_pp.sv - directed self-checking bench for weight_bank_pp
module tb_weight_bank_pp;
    localparam int NB = 8;
    localparam int KP = 9;
    localparam int DW = 8;
    localparam int DP = 512;
    localparam int AW = 9;
    localparam int RW = NB * KP * DW;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    weight_bank_pp_if #(.NUM_BANKS(NB), .KPOS(KP), .DATA_W(DW), .DEPTH(DP), .AW(AW)) bus ();

    weight_bank_pp #(.NUM_BANKS(NB), .KPOS(KP), .DATA_W(DW), .DEPTH(DP), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RW-1:0] pm_pack(input logic [NB-1:0][KP*DW-1:0] w, input logic [NB-1:0] m);
        logic [RW-1:0] r;
        r = '0;
        for (int b = 0; b < NB; b++)
            for (int p = 0; p < KP; p++)
                r[(p*NB + b)*DW +: DW] = m[b] ? w[b][p*DW +: DW] : 8'h00;
        return r;
    endfunction

    function automatic logic [KP*DW-1:0] rep(input logic [7:0] v);
        return {KP{v}};
    endfunction

    task automatic start_load(input int len);
        bus.load_start = 1'b1;
        bus.load_len   = (AW+1)'(len);
        tick();
        bus.load_start = 1'b0;
    endtask

    task automatic beat(input logic [KP*DW-1:0] d);
        int n;
        n = 0;
        while (!bus.wr_ready && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) chk("wr_ready_timeout", RW'(bus.wr_ready), RW'(1));
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic swap();
        bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
    endtask

    task automatic read1(input int addr, input logic [NB-1:0] m);
        bus.rd_en   = 1'b1;
        bus.rd_addr = AW'(addr);
        bus.rd_mask = m;
        tick();
        bus.rd_en = 1'b0;
        tick();
        chk("rd_valid_early", RW'(bus.rd_valid), RW'(0));
        tick();
        chk("rd_valid_lat3", RW'(bus.rd_valid), RW'(1));
    endtask

    logic [NB-1:0][KP*DW-1:0] w;
    logic [RW-1:0] old_exp;
    logic [RW-1:0] new_exp;

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.load_start = 1'b0;
        bus.load_len   = '0;
        bus.wr_valid   = 1'b0;
        bus.wr_data    = '0;
        bus.swap_req   = 1'b0;
        bus.rd_en      = 1'b0;
        bus.rd_addr    = '0;
        bus.rd_mask    = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_wr_ready", RW'(bus.wr_ready), RW'(0));
        chk("rst_rd_valid", RW'(bus.rd_valid), RW'(0));
        chk("rst_rd_data", bus.rd_data, '0);
        chk("rst_active_buf", RW'(bus.active_buf), RW'(0));
        chk("rst_shadow_full", RW'(bus.shadow_full), RW'(0));
        chk("rst_load_busy", RW'(bus.load_busy), RW'(0));

        // basic load of one address, swap, read
        start_load(1);
        chk("t1_load_busy", RW'(bus.load_busy), RW'(1));
        chk("t1_wr_ready", RW'(bus.wr_ready), RW'(1));
        for (int b = 0; b < NB; b++) begin
            w[b] = rep(8'((b + 1) * 16));
            beat(w[b]);
        end
        chk("t1_shadow_full", RW'(bus.shadow_full), RW'(1));
        chk("t1_wr_ready_off", RW'(bus.wr_ready), RW'(0));
        chk("t1_active_pre", RW'(bus.active_buf), RW'(0));
        swap();
        chk("t1_active_post", RW'(bus.active_buf), RW'(1));
        chk("t1_shadow_clr", RW'(bus.shadow_full), RW'(0));
        read1(0, 8'hFF);
        chk("t1_data", bus.rd_data, pm_pack(w, 8'hFF));
        chk("t1_b0p0", RW'(bus.rd_data[7:0]), RW'(8'h10));
        chk("t1_b1p0", RW'(bus.rd_data[15:8]), RW'(8'h20));
        chk("t1_b7p8", RW'(bus.rd_data[RW-1 -: 8]), RW'(8'h80));

        // load buffer 0 with 11 addresses, swap, back-to-back reads 5,10,5
        start_load(11);
        for (int a = 0; a < 11; a++) begin
            for (int b = 0; b < NB; b++) begin
                if (a == 5)       beat(72'hDEADBEEFCAFE000000);
                else if (a == 10) beat(72'h123456789ABCDEF000);
                else              beat(rep(8'(8'hA0 + a)));
            end
        end
        chk("t2_shadow_full", RW'(bus.shadow_full), RW'(1));
        swap();
        chk("t2_active", RW'(bus.active_buf), RW'(0));
        bus.rd_mask = 8'hFF;
        bus.rd_en = 1'b1;
        bus.rd_addr = 9'd5;
        tick();
        bus.rd_addr = 9'd10;
        tick();
        bus.rd_addr = 9'd5;
        tick();
        bus.rd_en = 1'b0;
        chk("t2_v0", RW'(bus.rd_valid), RW'(1));
        chk("t2_d0", bus.rd_data, pm_pack({NB{72'hDEADBEEFCAFE000000}}, 8'hFF));
        chk("t2_d0_b0p3", RW'(bus.rd_data[199:192]), RW'(8'hFE));
        tick();
        chk("t2_v1", RW'(bus.rd_valid), RW'(1));
        chk("t2_d1", bus.rd_data, pm_pack({NB{72'h123456789ABCDEF000}}, 8'hFF));
        chk("t2_d1_b0p3", RW'(bus.rd_data[199:192]), RW'(8'hBC));
        tick();
        chk("t2_v2", RW'(bus.rd_valid), RW'(1));
        chk("t2_d2", bus.rd_data, pm_pack({NB{72'hDEADBEEFCAFE000000}}, 8'hFF));
        tick();
        chk("t2_v_off", RW'(bus.rd_valid), RW'(0));

        // continuous reads of addr 0 while loading buffer 1 with 0x55, then swap
        old_exp = pm_pack({NB{rep(8'hA0)}}, 8'hFF);
        new_exp = pm_pack({NB{rep(8'h55)}}, 8'hFF);
        bus.rd_en = 1'b1;
        bus.rd_addr = 9'd0;
        tick();
        tick();
        tick();
        start_load(1);
        for (int b = 0; b < NB; b++) begin
            chk("t3_iso_v", RW'(bus.rd_valid), RW'(1));
            chk("t3_iso_d", bus.rd_data, old_exp);
            beat(rep(8'h55));
        end
        chk("t3_shadow_full", RW'(bus.shadow_full), RW'(1));
        swap();
        chk("t3_swap_d0", bus.rd_data, old_exp);
        tick();
        chk("t3_swap_d1", bus.rd_data, old_exp);
        tick();
        chk("t3_swap_d2", bus.rd_data, old_exp);
        tick();
        chk("t3_swap_d3", bus.rd_data, new_exp);
        bus.rd_en = 1'b0;
        tick();
        tick();
        tick();

        // mask only bank 0
        read1(0, 8'h01);
        chk("t4_mask", bus.rd_data, pm_pack({NB{rep(8'h55)}}, 8'h01));
        chk("t4_b0p0", RW'(bus.rd_data[7:0]), RW'(8'h55));
        chk("t4_b1p0", RW'(bus.rd_data[15:8]), RW'(8'h00));
        chk("t4_b0p1", RW'(bus.rd_data[71:64]), RW'(8'h55));

        // swap ignored without full shadow, zero-length and mid-load starts ignored
        swap();
        chk("t5_swap_ign", RW'(bus.active_buf), RW'(1));
        start_load(0);
        chk("t5_len0_ign", RW'(bus.load_busy), RW'(0));
        start_load(2);
        for (int i = 0; i < 15; i++) begin
            if (i == 5) start_load(1);
            beat(rep(8'(8'h30 + i)));
        end
        chk("t5_not_full", RW'(bus.shadow_full), RW'(0));
        chk("t5_still_busy", RW'(bus.load_busy), RW'(1));
        bus.swap_req = 1'b1;
        beat(rep(8'h3F));
        bus.swap_req = 1'b0;
        chk("t5_lastbeat_swap_ign", RW'(bus.active_buf), RW'(1));
        chk("t5_full", RW'(bus.shadow_full), RW'(1));
        swap();
        chk("t5_active", RW'(bus.active_buf), RW'(0));
        for (int b = 0; b < NB; b++) w[b] = rep(8'(8'h38 + b));
        read1(1, 8'hFF);
        chk("t5_addr1", bus.rd_data, pm_pack(w, 8'hFF));

        // reset in the middle of a load, with a read in flight
        start_load(2);
        for (int i = 0; i < 5; i++) beat(rep(8'hEE));
        bus.rd_en = 1'b1;
        bus.rd_addr = 9'd0;
        bus.rd_mask = 8'hFF;
        tick();
        bus.rd_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_wr_ready", RW'(bus.wr_ready), RW'(0));
        chk("t6_load_busy", RW'(bus.load_busy), RW'(0));
        chk("t6_shadow_full", RW'(bus.shadow_full), RW'(0));
        chk("t6_rd_valid", RW'(bus.rd_valid), RW'(0));
        chk("t6_active", RW'(bus.active_buf), RW'(0));
        tick();
        chk("t6_rd_valid_later", RW'(bus.rd_valid), RW'(0));
        start_load(1);
        for (int b = 0; b < NB; b++) begin
            w[b] = rep(8'(8'h70 + b));
            beat(w[b]);
        end
        chk("t6_full", RW'(bus.shadow_full), RW'(1));
        swap();
        chk("t6_active_post", RW'(bus.active_buf), RW'(1));
        read1(0, 8'hFF);
        chk("t6_data", bus.rd_data, pm_pack(w, 8'hFF));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
